seq_signed_divider: RTL and testbench



---
 rtl/seq_signed_divider_if.sv | 14 +
 rtl/seq_signed_divider.sv | 67 ++++++
 tb/tb_seq_signed_divider.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_signed_divider_if.sv
// seq_signed_divider_if: request/result bundle for the sequential signed divider
interface seq_signed_divider_if #(parameter int N = 8);
  logic start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic busy;
  logic done;
  logic div_by_zero;
  logic ovf;
  modport master(output start, dividend, divisor, input quotient, remainder, busy, done, div_by_zero, ovf);
  modport slave(input start, dividend, divisor, output quotient, remainder, busy, done, div_by_zero, ovf);
endinterface

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: signed N-bit restoring divider, one quotient bit per cycle
module seq_signed_divider #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  seq_signed_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(N + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0] a, r, r_nx;
  logic [N:0] b, t;
  logic q_neg, r_neg, dz, ov, ge;
  // a shifts dividend magnitude bits out of its top while quotient bits enter at the bottom
  assign t = {r, a[N-1]};
  assign ge = t >= b;
  assign r_nx = ge ? N'(t - b) : t[N-1:0];
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (bus.start ? CALC : IDLE) :
          state == CALC ? (cnt == CW'(1) ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      a <= '0;
      r <= '0;
      b <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz <= 1'b0;
      ov <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.done <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      bus.done <= state == DONE;
      if (state == IDLE && bus.start) begin
        a <= bus.dividend[N-1] ? -bus.dividend : bus.dividend;
        b <= bus.divisor[N-1] ? -{1'b1, bus.divisor} : {1'b0, bus.divisor};
        q_neg <= bus.dividend[N-1] ^ bus.divisor[N-1];
        r_neg <= bus.dividend[N-1];
        r <= '0;
        cnt <= CW'(N);
        dz <= bus.divisor == '0;
        ov <= bus.dividend == {1'b1, {(N-1){1'b0}}} && bus.divisor == '1;
      end
      if (state == CALC) begin
        a <= {a[N-2:0], ge};
        r <= r_nx;
        cnt <= cnt - 1'b1;
      end
      // with a zero divisor every step subtracts nothing, so r ends up as |dividend|
      if (state == DONE) begin
        bus.quotient <= dz ? '1 : q_neg ? -a : a;
        bus.remainder <= r_neg ? -r : r;
        bus.div_by_zero <= dz;
        bus.ovf <= ov;
      end
    end
  end
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed and random checks against a behavioural division model
module tb_seq_signed_divider;
  localparam int N = 8;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 0;
  seq_signed_divider_if #(.N(N)) bus();
  seq_signed_divider #(.N(N)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] expect_of(input logic signed [7:0] a, input logic signed [7:0] b);
    int q, r;
    logic dz, ov;
    dz = 0;
    ov = 0;
    if (b == 0) begin q = -1; r = a; dz = 1; end
    else if (a == -128 && b == -1) begin q = -128; r = 0; ov = 1; end
    else begin q = int'(a) / int'(b); r = int'(a) % int'(b); end
    return {8'(q), 8'(r), dz, ov};
  endfunction

  logic [7:0] m_q = 0, m_r = 0;
  logic m_dz = 0, m_ov = 0, m_done = 0, m_busy = 0;
  logic [17:0] pend = 0;
  int edge_n = 0, m_end = 0;
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (rst) begin
      m_busy <= 0;
      m_done <= 0;
      {m_q, m_r, m_dz, m_ov} <= '0;
    end else begin
      m_done <= 0;
      if (m_busy && edge_n == m_end) begin
        m_busy <= 0;
        m_done <= 1;
        {m_q, m_r, m_dz, m_ov} <= pend;
      end else if (!m_busy && bus.start) begin
        m_busy <= 1;
        m_end <= edge_n + N + 1;
        pend <= expect_of(bus.dividend, bus.divisor);
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("cyc_busy", int'(bus.busy), int'(m_busy));
    check("cyc_done", int'(bus.done), int'(m_done));
    check("cyc_q", int'(bus.quotient), int'(m_q));
    check("cyc_r", int'(bus.remainder), int'(m_r));
    check("cyc_dz", int'(bus.div_by_zero), int'(m_dz));
    check("cyc_ovf", int'(bus.ovf), int'(m_ov));
  end

  task automatic wait_done(output int cyc, output int busy_low);
    cyc = 0;
    busy_low = 0;
    do begin
      @(negedge clk);
      bus.start = 0;
      cyc++;
      if (!bus.done && !bus.busy) busy_low++;
    end while (!bus.done && cyc < 40);
  endtask

  task automatic run(input logic signed [7:0] a, input logic signed [7:0] b, input int eq, input int er, input int edz, input int eov);
    int cyc, bl;
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1;
    wait_done(cyc, bl);
    check("latency", cyc, N + 2);
    check("quotient", int'($signed(bus.quotient)), eq);
    check("remainder", int'($signed(bus.remainder)), er);
    check("div_by_zero", int'(bus.div_by_zero), edz);
    check("ovf", int'(bus.ovf), eov);
    check("identity", int'(8'($signed(bus.quotient) * b + $signed(bus.remainder))), int'(8'(a)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q"}, int'(bus.quotient), 0);
    check({tag, "_r"}, int'(bus.remainder), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_dz"}, int'(bus.div_by_zero), 0);
    check({tag, "_ovf"}, int'(bus.ovf), 0);
  endtask

  initial begin
    int cyc, bl, dones;
    logic signed [7:0] a, b;
    bus.start = 0;
    bus.dividend = 0;
    bus.divisor = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check_zero("reset");
    rst = 0;
    run(81, 7, 11, 4, 0, 0);
    run(-81, 7, -11, -4, 0, 0);
    run(81, -7, -11, 4, 0, 0);
    run(-81, -7, 11, -4, 0, 0);
    run(-128, -1, -128, 0, 0, 1);
    run(-128, 1, -128, 0, 0, 0);
    run(-128, 7, -18, -2, 0, 0);
    run(5, 0, -1, 5, 1, 0);
    run(6, 3, 2, 0, 0, 0);
    run(-7, 0, -1, -7, 1, 0);
    run(127, -128, 0, 127, 0, 0);
    bus.dividend = 81;
    bus.divisor = 7;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    bus.dividend = 5;
    bus.divisor = 1;
    bus.start = 1;
    wait_done(cyc, bl);
    check("repulse_latency", cyc + 2, N + 2);
    check("repulse_busy_low", bl, 0);
    check("repulse_q", int'($signed(bus.quotient)), 11);
    check("repulse_r", int'($signed(bus.remainder)), 4);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    check("repulse_extra_done", dones, 0);
    bus.dividend = -81;
    bus.divisor = 7;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_zero("abort");
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    check("abort_no_done", dones, 0);
    run(100, 9, 11, 1, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      do begin
        a = 8'($urandom);
        b = 8'($urandom);
      end while (b == 0 || (a == -128 && b == -1));
      run(a, b, int'(a) / int'(b), int'(a) % int'(b), 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
